vram_slot_arbiter: RTL

- Time-division scheduler for a single shared 2K×8 video SRAM.
  - Screen RAM occupies 0x000–0x3FF (A10=0).
  - Character RAM occupies 0x400–0x7FF (A10=1).
- Each 8-pixel character cell is split into fixed slots: video fetches (screen code, then pattern) and one CPU access window.
- Sits between the CPU VRAM decode/wait logic, the master pixel/line counters, and the pixel serializer, replacing the separate screen/char RAM enables.

---
 rtl/vram_slot_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_slot_arbiter.sv
// Purpose : time-division scheduler sharing one 2Kx8 video SRAM between the
//           video fetch (screen code, then glyph pattern) and a single CPU access per cell.
// Latency : video read = 2 clk per fetch (phases 0-1, 2-3); CPU access = SETUP/STROBE/HOLD, wait released in DONE.
// Backpressure: the CPU is held off via cpu_wait_n until its access completes; video is never stalled.
//
// Ports:
//   clk, rst_n                - master pixel clock, async active-low reset
//   viden, phase, col, row, line - display window and master counter taps
//   cpu_req_n, cpu_wr_n, cpu_a, cpu_dout, cpu_din, cpu_wait_n - CPU VRAM port
//   sram_a, sram_dq_i, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n - SRAM pins
//   pat, inv, pat_ld          - glyph byte, inverse flag and load strike to the serializer
module vram_slot_arbiter #(
  parameter int AW             = 11,
  parameter int CPU_SLOT_FIRST = 4,
  parameter int CPU_SLOT_LAST  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          viden,
  input  logic [2:0]    phase,
  input  logic [4:0]    col,
  input  logic [4:0]    row,
  input  logic [2:0]    line,
  input  logic          cpu_req_n,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  output logic [AW-1:0] sram_a,
  input  logic [7:0]    sram_dq_i,
  output logic [7:0]    sram_dq_o,
  output logic          sram_dq_oe,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [7:0]    pat,
  output logic          inv,
  output logic          pat_ld
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            fetch_en_q, fetch_en_d;
  logic [7:0]      code_q, code_d;
  logic [7:0]      pat_q, pat_d;
  logic            inv_q, inv_d;
  logic            pat_ld_q, pat_ld_d;
  logic [7:0]      cpu_din_q, cpu_din_d;
  logic [AW-1:0]   acc_a_q, acc_a_d;
  logic [7:0]      acc_dat_q, acc_dat_d;
  logic            acc_wr_n_q, acc_wr_n_d;

  logic            fetch;
  logic            vid_scr;
  logic            vid_chr;
  logic            cpu_act;
  logic            start_ok;
  logic [2:0]      next_phase;
  logic [10:0]     scr_addr;
  logic [10:0]     chr_addr;

  // viden is only guaranteed valid at phase 0; the latched copy covers phases 1-7.
  assign fetch   = (phase == 3'd0) ? viden : fetch_en_q;
  // Each video read holds address and OE for two phases; data is captured at the end of the second.
  assign vid_scr = fetch && ((phase == 3'd0) || (phase == 3'd1));
  assign vid_chr = fetch && ((phase == 3'd2) || (phase == 3'd3));
  assign cpu_act = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);

  assign scr_addr = {1'b0, row, col};
  assign chr_addr = {1'b1, code_q[6:0], line};

  // The start window is judged on the phase the SETUP cycle will occupy.
  // During active display that keeps SETUP..HOLD inside phases 4-7, clear of
  // the fetch slots at 0-3. In blanking any SETUP up to phase 5 still ends
  // its HOLD by phase 7.
  assign next_phase = phase + 3'd1;
  always_comb begin
    start_ok = 1'b0;
    if (viden) begin
      start_ok = (int'(next_phase) >= CPU_SLOT_FIRST) && (int'(next_phase) <= CPU_SLOT_LAST);
    end else begin
      start_ok = (next_phase <= 3'd5);
    end
  end

  assign cpu_wait_n = !(!cpu_req_n && (state_q != DONE));

  // Next-state and SRAM pin decode
  always_comb begin
    state_d    = state_q;
    acc_a_d    = acc_a_q;
    acc_dat_d  = acc_dat_q;
    acc_wr_n_d = acc_wr_n_q;
    cpu_din_d  = cpu_din_q;

    sram_a     = '0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = acc_dat_q;

    case (state_q)
      IDLE: begin
        if (!cpu_req_n && start_ok) begin
          state_d    = SETUP;
          acc_a_d    = cpu_a;
          acc_dat_d  = cpu_dout;
          acc_wr_n_d = cpu_wr_n;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        state_d = HOLD;
        if (acc_wr_n_q) begin
          cpu_din_d = sram_dq_i;
        end
      end
      HOLD:   state_d = DONE;
      DONE: begin
        if (cpu_req_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Video first: the start window already keeps the CPU out of these slots.
    if (vid_scr) begin
      sram_a    = AW'(scr_addr);
      sram_oe_n = 1'b0;
    end else if (vid_chr) begin
      sram_a    = AW'(chr_addr);
      sram_oe_n = 1'b0;
    end else if (cpu_act) begin
      sram_a     = acc_a_q;
      // Data bus only driven on writes, and OE only pulses on reads,
      // so the two never overlap.
      sram_dq_oe = !acc_wr_n_q;
      if (state_q == STROBE) begin
        sram_oe_n = !acc_wr_n_q;
        sram_we_n = acc_wr_n_q;
      end
    end
  end

  // Video fetch pipeline
  always_comb begin
    fetch_en_d = fetch_en_q;
    code_d     = code_q;
    pat_d      = pat_q;
    inv_d      = inv_q;
    pat_ld_d   = (phase == 3'd6);

    if (phase == 3'd0) begin
      fetch_en_d = viden;
    end
    if ((phase == 3'd1) && fetch) begin
      code_d = sram_dq_i;
    end
    if (phase == 3'd3) begin
      pat_d = fetch ? sram_dq_i : 8'h00;
      inv_d = fetch ? code_q[7] : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_en_q <= 1'b0;
      code_q     <= 8'h00;
      pat_q      <= 8'h00;
      inv_q      <= 1'b0;
      pat_ld_q   <= 1'b0;
      cpu_din_q  <= 8'h00;
      acc_a_q    <= '0;
      acc_dat_q  <= 8'h00;
      acc_wr_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_en_q <= fetch_en_d;
      code_q     <= code_d;
      pat_q      <= pat_d;
      inv_q      <= inv_d;
      pat_ld_q   <= pat_ld_d;
      cpu_din_q  <= cpu_din_d;
      acc_a_q    <= acc_a_d;
      acc_dat_q  <= acc_dat_d;
      acc_wr_n_q <= acc_wr_n_d;
    end
  end

  assign pat     = pat_q;
  assign inv     = inv_q;
  assign pat_ld  = pat_ld_q;
  assign cpu_din = cpu_din_q;

endmodule
